if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 98 +++++++++
 tb/tb_if_stage.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`timescale 1ns/1ps
// Instruction fetch: issues word fetches, queues returned words in a 2-entry IF/ID buffer.
// Latency 2 cycles from request accept to id_valid; stops issuing when buffer+in-flight reach 2, never stalls responses.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_ia_plus_4
);

  logic [31:0] pc;
  logic [1:0]  occ;
  logic [1:0]  outst;
  logic [1:0]  drop;
  logic        fifo_rd, fifo_wr;
  logic        pend_rd, pend_wr;
  logic [31:0] fifo_ir   [2];
  logic [31:0] fifo_iap4 [2];
  logic [31:0] pend_iap4 [2];

  logic        pop, push, accept, rsp_drop;
  logic [2:0]  in_flight;
  logic        unused_bits;

  assign unused_bits = ^redirect_target[1:0];

  assign id_valid     = (occ != 2'd0) && !redirect_valid;
  assign id_ir        = fifo_ir[fifo_rd];
  assign id_ia_plus_4 = fifo_iap4[fifo_rd];
  assign pop          = id_valid && id_ready;

  // Buffer slots plus in-flight fetches may never exceed the two buffer entries.
  assign in_flight      = {1'b0, occ} + {1'b0, outst} - {2'b00, pop};
  assign imem_req_valid = rst_n && !redirect_valid && (in_flight < 3'd2);
  assign imem_req_addr  = {pc[31:2], 2'b00};
  assign accept         = imem_req_valid && imem_req_ready;

  // A response landing in a redirect cycle belongs to the old stream.
  assign rsp_drop = imem_rsp_valid && ((drop != 2'd0) || redirect_valid);
  assign push     = imem_rsp_valid && !rsp_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= {RESET_VECTOR[31:2], 2'b00};
      occ     <= 2'd0;
      outst   <= 2'd0;
      drop    <= 2'd0;
      fifo_rd <= 1'b0;
      fifo_wr <= 1'b0;
      pend_rd <= 1'b0;
      pend_wr <= 1'b0;
    end else begin
      outst <= outst + {1'b0, accept} - {1'b0, imem_rsp_valid};
      if (accept) begin
        pc      <= pc + 32'd4;
        pend_wr <= ~pend_wr;
      end
      if (imem_rsp_valid)
        pend_rd <= ~pend_rd;
      if (redirect_valid) begin
        pc      <= {redirect_target[31:2], 2'b00};
        drop    <= outst - {1'b0, imem_rsp_valid};
        occ     <= 2'd0;
        fifo_rd <= 1'b0;
        fifo_wr <= 1'b0;
      end else begin
        if (imem_rsp_valid && drop != 2'd0)
          drop <= drop - 2'd1;
        occ <= occ + {1'b0, push} - {1'b0, pop};
        if (push)
          fifo_wr <= ~fifo_wr;
        if (pop)
          fifo_rd <= ~fifo_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      pend_iap4[pend_wr] <= imem_req_addr + 32'd4;
    if (push) begin
      fifo_ir[fifo_wr]   <= imem_rsp_data;
      fifo_iap4[fifo_wr] <= pend_iap4[pend_rd];
    end
  end

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
// Directed bench for if_stage with a small in-order memory whose response can be held off.
module tb_if_stage;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_valid, id_ready;
  logic [31:0] id_ir, id_ia_plus_4;

  logic [31:0] q[$];
  bit          rsp_en;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_ir(id_ir), .id_ia_plus_4(id_ia_plus_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Present the oldest accepted fetch as this cycle's response, then let outputs settle.
  task automatic settle();
    imem_rsp_valid = rsp_en && (q.size() > 0);
    imem_rsp_data  = (q.size() > 0) ? (q[0] ^ K) : 32'h0;
    #1;
  endtask

  task automatic tick();
    bit          acc;
    bit          rsp;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    rsp = imem_rsp_valid;
    a   = imem_req_addr;
    @(posedge clk);
    if (rsp) void'(q.pop_front());
    if (acc) q.push_back(a);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    rsp_en = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = 32'h0;
    id_ready = 1'b1;
    imem_req_ready = 1'b1;
    settle();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;

    // Streaming from reset with a 1-cycle memory.
    do_reset();
    settle(); chk("s_c0_req", {31'b0, imem_req_valid}, 32'd1); chk("s_c0_addr", imem_req_addr, 32'h0);
    chk("s_c0_idv", {31'b0, id_valid}, 32'd0); tick();
    settle(); chk("s_c1_addr", imem_req_addr, 32'h4); chk("s_c1_idv", {31'b0, id_valid}, 32'd0); tick();
    settle(); chk("s_c2_idv", {31'b0, id_valid}, 32'd1); chk("s_c2_ia4", id_ia_plus_4, 32'h4);
    chk("s_c2_ir", id_ir, 32'hA5A5_0000); chk("s_c2_addr", imem_req_addr, 32'h8); tick();
    settle(); chk("s_c3_ia4", id_ia_plus_4, 32'h8); chk("s_c3_ir", id_ir, 32'hA5A5_0004);
    chk("s_c3_addr", imem_req_addr, 32'hC); tick();
    settle(); chk("s_c4_ia4", id_ia_plus_4, 32'hC); chk("s_c4_idv", {31'b0, id_valid}, 32'd1); tick();

    // Decode stalled: only two fetches, head held, then one issue per pop.
    do_reset();
    id_ready = 1'b0;
    settle(); tick();
    settle(); chk("st_c1_addr", imem_req_addr, 32'h4); tick();
    settle(); chk("st_c2_req", {31'b0, imem_req_valid}, 32'd0); chk("st_c2_ia4", id_ia_plus_4, 32'h4); tick();
    settle(); chk("st_c3_req", {31'b0, imem_req_valid}, 32'd0); chk("st_c3_ia4", id_ia_plus_4, 32'h4);
    chk("st_c3_ir", id_ir, 32'hA5A5_0000); tick();
    id_ready = 1'b1;
    settle(); chk("st_c4_req", {31'b0, imem_req_valid}, 32'd1); chk("st_c4_addr", imem_req_addr, 32'h8); tick();
    settle(); chk("st_c5_ia4", id_ia_plus_4, 32'h8); chk("st_c5_addr", imem_req_addr, 32'hC);
    id_ready = 1'b0; tick();
    settle(); chk("st_c6_full", {31'b0, imem_req_valid}, 32'd0);

    // Asynchronous reset with a full buffer clears outputs without a clock edge.
    #2 rst_n = 1'b0; #1;
    chk("ar_idv", {31'b0, id_valid}, 32'd0); chk("ar_req", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    do_reset();
    settle(); chk("ar_first_addr", imem_req_addr, 32'h0); chk("ar_first_req", {31'b0, imem_req_valid}, 32'd1);

    // Redirect with two fetches in flight: both responses dropped.
    do_reset();
    rsp_en = 1'b0;
    settle(); tick();
    settle(); tick();
    settle(); chk("rd2_c2_req", {31'b0, imem_req_valid}, 32'd0); tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
    settle(); chk("rd2_c3_idv", {31'b0, id_valid}, 32'd0); chk("rd2_c3_req", {31'b0, imem_req_valid}, 32'd0); tick();
    rsp_en = 1'b1;
    settle(); chk("rd2_c4_req", {31'b0, imem_req_valid}, 32'd0); tick();
    settle(); chk("rd2_c5_addr", imem_req_addr, 32'h100); chk("rd2_c5_idv", {31'b0, id_valid}, 32'd0); tick();
    settle(); chk("rd2_c6_idv", {31'b0, id_valid}, 32'd0); chk("rd2_c6_addr", imem_req_addr, 32'h104); tick();
    settle(); chk("rd2_c7_idv", {31'b0, id_valid}, 32'd1); chk("rd2_c7_ia4", id_ia_plus_4, 32'h104);
    chk("rd2_c7_ir", id_ir, 32'hA5A5_0100); tick();

    // Redirect coinciding with a response while another fetch is in flight.
    do_reset();
    rsp_en = 1'b0;
    settle(); tick();
    settle(); tick();
    rsp_en = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0200;
    settle(); chk("rr_c2_rsp", {31'b0, imem_rsp_valid}, 32'd1); chk("rr_c2_idv", {31'b0, id_valid}, 32'd0);
    chk("rr_c2_req", {31'b0, imem_req_valid}, 32'd0); tick();
    settle(); chk("rr_c3_idv", {31'b0, id_valid}, 32'd0); chk("rr_c3_addr", imem_req_addr, 32'h200); tick();
    settle(); chk("rr_c4_idv", {31'b0, id_valid}, 32'd0); tick();
    settle(); chk("rr_c5_ia4", id_ia_plus_4, 32'h204); chk("rr_c5_ir", id_ir, 32'hA5A5_0200); tick();

    // Back-to-back redirects: only the last target fetched.
    do_reset();
    settle(); tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0300;
    settle(); tick();
    redirect_valid = 1'b1; redirect_target = 32'h0000_0400;
    settle(); chk("bb_c2_req", {31'b0, imem_req_valid}, 32'd0); tick();
    settle(); chk("bb_c3_addr", imem_req_addr, 32'h400); chk("bb_c3_idv", {31'b0, id_valid}, 32'd0); tick();
    settle(); tick();
    settle(); chk("bb_c5_ia4", id_ia_plus_4, 32'h404); chk("bb_c5_ir", id_ir, 32'hA5A5_0400);

    // Address wrap at the top of the space.
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    settle(); tick();
    settle(); chk("wr_c1_addr", imem_req_addr, 32'hFFFF_FFFC); tick();
    settle(); chk("wr_c2_addr", imem_req_addr, 32'h0); tick();
    settle(); chk("wr_c3_idv", {31'b0, id_valid}, 32'd1); chk("wr_c3_ia4", id_ia_plus_4, 32'h0);
    chk("wr_c3_ir", id_ir, 32'h5A5A_FFFC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
